// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier control FSM and its datapath command bundle.
// Ports: clk, rst, start, Q_LSB in; mult_control, busy, done out.
`timescale 1ns/1ps

package booth_pkg;
  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic add_sub;
    logic shift_HQ_LQ_Q_1;
  } mult_control_t;
endpackage

module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    Q_LSB,
  output mult_control_t mult_control,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    mult_control = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        mult_control.load_A = 1'b1;
        mult_control.load_B = 1'b1;
        busy      = 1'b1;
        w_cnt_nxt = CW'(N);
        w_next    = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        // 01: add M, 10: subtract M, 00/11: no change
        mult_control.load_add = Q_LSB[0] ^ Q_LSB[1];
        mult_control.add_sub  = ~Q_LSB[1] & Q_LSB[0];
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        mult_control.shift_HQ_LQ_Q_1 = 1'b1;
        busy      = 1'b1;
        w_cnt_nxt = r_cnt - CW'(1);
        w_next    = (r_cnt == CW'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl at N=8 and N=4 with a
// behavioural Booth datapath attached to each instance.
`timescale 1ns/1ps

module tb_booth_mult_ctrl;
  import booth_pkg::*;

  typedef struct {
    int  prod;
    int  cyc;
    bit  chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [1:0] q_rand = '0;
  int         q_mode = 0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  // Expected {load_A,load_B,load_add,add_sub,shift,busy,done}
  // from the position within an operation (cycle index since start).
  function automatic logic [6:0] expect_v(int rel, int nn,
                                          logic [1:0] q);
    logic [6:0] v;
    v = '0;
    if (rel == 1) begin
      v = 7'b1100010;
    end else if (rel >= 2 && rel <= 2 * nn + 1) begin
      v[1] = 1'b1;
      if (rel % 2 == 0) begin
        v[4] = (q == 2'b01) || (q == 2'b10);
        v[3] = (q == 2'b01);
      end else begin
        v[2] = 1'b1;
      end
    end else if (rel == 2 * nn + 2) begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NN = (g == 0) ? 8 : 4;

    mult_control_t   ctrl;
    logic            bsy;
    logic            dn;
    logic [1:0]      qlsb;
    logic [NN-1:0]   M;
    logic [NN-1:0]   LQ;
    logic [NN:0]     HQ;
    logic            Q1;
    logic [2*NN-1:0] y;
    exp_t            sb[$];
    int              rel;

    booth_mult_ctrl #(.N(NN)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .Q_LSB        (qlsb),
      .mult_control (ctrl),
      .busy         (bsy),
      .done         (dn)
    );

    assign y    = {HQ[NN-1:0], LQ};
    assign qlsb = (q_mode == 0) ? {LQ[0], Q1} :
                  (q_mode == 1) ? 2'b00 : q_rand;

    // HQ carries one guard bit so M = most-negative still works.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        M  <= '0;
        LQ <= '0;
        HQ <= '0;
        Q1 <= 1'b0;
      end else begin
        if (ctrl.load_A) M <= A[NN-1:0];
        if (ctrl.load_B) begin
          LQ <= B[NN-1:0];
          HQ <= '0;
          Q1 <= 1'b0;
        end else if (ctrl.load_add) begin
          HQ <= ctrl.add_sub ? HQ + {M[NN-1], M}
                             : HQ - {M[NN-1], M};
        end else if (ctrl.shift_HQ_LQ_Q_1) begin
          {HQ, LQ, Q1} <= {HQ[NN], HQ, LQ};
        end
      end
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rel <= -1;
        sb.delete();
      end else if (rel == -1) begin
        if (start) begin
          exp_t e;
          e.prod = int'($signed(A[NN-1:0])) * int'($signed(B[NN-1:0]));
          e.cyc  = cyc + 2 * NN + 2;
          e.chk  = (q_mode == 0);
          sb.push_back(e);
          rel <= 1;
        end
      end else if (rel == 2 * NN + 2) begin
        rel <= -1;
      end else begin
        rel <= rel + 1;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        check($sformatf("ctrl%0d", NN),
              {25'd0, ctrl, bsy, dn},
              {25'd0, expect_v(rel, NN, qlsb)});
        assert (!(ctrl.load_add && ctrl.shift_HQ_LQ_Q_1))
          else $error("load_add with shift in N=%0d", NN);
        if (ctrl.load_add || ctrl.shift_HQ_LQ_Q_1)
          check($sformatf("excl%0d", NN),
                {31'd0, ctrl.load_add & ctrl.shift_HQ_LQ_Q_1}, 0);
        if (dn) begin
          if (sb.size() == 0) begin
            check($sformatf("done_unexp%0d", NN), 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("done_cyc%0d", NN), cyc, e.cyc);
            if (e.chk)
              check($sformatf("product%0d", NN), {16'd0, y},
                    e.prod & ((1 << (2 * NN)) - 1));
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      q_rand = 2'($urandom);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(24);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_ctrl8", {25'd0, u[0].ctrl, u[0].bsy, u[0].dn}, 0);
    check("rst_ctrl4", {25'd0, u[1].ctrl, u[1].bsy, u[1].dn}, 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // Reset at cycle 5 aborts, then a clean restart.
    A = 8'h35;
    B = 8'hC7;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(4);
    #2 rst = 1'b1;
    #1;
    check("rst_mid8", {25'd0, u[0].ctrl, u[0].bsy, u[0].dn}, 0);
    check("rst_mid4", {25'd0, u[1].ctrl, u[1].bsy, u[1].dn}, 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    op(8'h35, 8'hC7);

    // Q_LSB held at 00, then random Booth pairs per EVAL.
    q_mode = 1;
    op(8'h00, 8'h00);
    q_mode = 2;
    repeat (3) op(8'($urandom), 8'($urandom));
    q_mode = 0;

    // Start pulses at cycles 4 and 18 of a running operation.
    A = 8'h5A;
    B = 8'h93;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(3);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(13);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(25);

    // Operands including corners, N=4 case A=3, B=-2.
    op(8'h03, 8'hFE);
    op(8'h80, 8'h80);
    op(8'h7F, 8'h80);
    op(8'hFF, 8'h01);
    op(8'h00, 8'hAB);
    repeat (8) op(8'($urandom), 8'($urandom));

    // Back-to-back with start held high.
    A = 8'hB6;
    B = 8'h2D;
    start = 1'b1;
    cycles(60);
    start = 1'b0;
    cycles(25);

    check("sb_empty8", u[0].sb.size(), 0);
    check("sb_empty4", u[1].sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
